// File: rtl/conv_max_pool_2x2.sv
// conv_max_pool_2x2: 2x2 stride-2 signed max pooling over a raster stream of conv results.
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   enable            when low, input side and counters/FSM hold; output register still drains
//   in_valid/in_ready/in_data     conv result stream (raster order)
//   out_valid/out_ready/out_data  pooled result stream (raster order)
//   out_last          qualifies the final pooled result of a frame
//   frame_done        one-cycle pulse after the out_last handshake
module conv_max_pool_2x2 #(
    parameter int WIDTH      = 32,
    parameter int ARRAY_SIZE = 6,
    parameter int CNT_WIDTH  = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_last,
    output logic             frame_done
);
    localparam int HALF = ARRAY_SIZE / 2;
    localparam int LBW  = HALF > 1 ? $clog2(HALF) : 1;
    typedef enum logic {EVEN_ROW, ODD_ROW} state_t;
    state_t                  state, state_nx;
    logic [CNT_WIDTH-1:0]    col, row;
    logic signed [WIDTH-1:0] h_reg, hmax, vmax;
    logic signed [WIDTH-1:0] line_buf [0:(1<<LBW)-1];
    logic [LBW-1:0]          lb_idx;
    logic                    accept, col_last, row_last, emit;
    // Output register can be refilled in the same cycle it drains.
    assign in_ready = enable && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;
    assign col_last = col == CNT_WIDTH'(ARRAY_SIZE - 1);
    assign row_last = row == CNT_WIDTH'(ARRAY_SIZE - 1);
    assign lb_idx   = LBW'(col >> 1);
    assign hmax     = h_reg > $signed(in_data) ? h_reg : $signed(in_data);
    assign vmax     = line_buf[lb_idx] > hmax ? line_buf[lb_idx] : hmax;
    // Bottom-right pixel of a window completes a pooled result.
    assign emit     = accept && state == ODD_ROW && col[0];
    always_comb begin
        state_nx = (accept && col_last) ? (state == EVEN_ROW ? ODD_ROW : EVEN_ROW) : state;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= EVEN_ROW;
        else     state <= state_nx;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col        <= '0;
            row        <= '0;
            h_reg      <= '0;
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_last   <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= out_valid && out_ready && out_last;
            if (accept) begin
                col      <= col_last ? '0 : col + 1'b1;
                out_last <= row_last && col_last;
                if (col_last) row <= row_last ? '0 : row + 1'b1;
                if (!col[0]) h_reg <= in_data;
            end
            if (emit) begin
                out_data  <= vmax;
                out_valid <= 1'b1;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end
    // Horizontal maxima of the even row; contents need no reset.
    always_ff @(posedge clk) begin
        if (accept && state == EVEN_ROW && col[0]) line_buf[lb_idx] <= hmax;
    end
endmodule

// File: tb/tb_conv_max_pool_2x2.sv
// tb_conv_max_pool_2x2: directed scenarios checked against a frame-array max-pool model.
module tb_conv_max_pool_2x2;
    localparam int W = 32;
    localparam int N = 6;
    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         enable = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] in_data = '0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [W-1:0] out_data;
    logic         out_last;
    logic         frame_done;
    typedef struct {int d; bit last;} exp_t;
    exp_t exp_q[$];
    int   log_q[$];
    int   pix[N*N];
    int   cnt = 0;
    int   acc_cnt = 0;
    int   fd_cnt = 0;
    bit   prev_last = 0;
    int   errors = 0;
    int   checks = 0;
    conv_max_pool_2x2 #(.WIDTH(W), .ARRAY_SIZE(N), .CNT_WIDTH(3)) dut (
        .clk(clk), .rst(rst), .enable(enable),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_last(out_last), .frame_done(frame_done)
    );
    always #5 clk = ~clk;
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
    task automatic chk(input string nm, input logic signed [63:0] act, input logic signed [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask
    // Model: store accepted pixels in a frame array; each odd/odd pixel closes a 2x2 window.
    always @(negedge clk) begin
        if (rst) begin
            chk("rst_out_valid", out_valid, 0);
            chk("rst_out_data", $signed(out_data), 0);
            chk("rst_out_last", out_last, 0);
            chk("rst_frame_done", frame_done, 0);
            exp_q.delete();
            cnt = 0;
            prev_last = 0;
        end else begin
            chk("in_ready", in_ready, enable && (!out_valid || out_ready));
            chk("frame_done", frame_done, prev_last);
            if (frame_done) fd_cnt++;
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    chk("spurious_out", $signed(out_data), -1);
                end else begin
                    chk("out_data", $signed(out_data), exp_q[0].d);
                    chk("out_last", out_last, exp_q[0].last);
                    if (out_ready) begin
                        log_q.push_back($signed(out_data));
                        void'(exp_q.pop_front());
                    end
                end
            end
            prev_last = out_valid && out_ready && out_last;
            if (in_valid && in_ready) begin
                int r, c, m;
                exp_t e;
                acc_cnt++;
                pix[cnt] = $signed(in_data);
                r = cnt / N;
                c = cnt % N;
                if (r % 2 == 1 && c % 2 == 1) begin
                    m = pix[cnt];
                    if (pix[cnt-1] > m) m = pix[cnt-1];
                    if (pix[cnt-N] > m) m = pix[cnt-N];
                    if (pix[cnt-N-1] > m) m = pix[cnt-N-1];
                    e.d = m;
                    e.last = (cnt == N*N-1);
                    exp_q.push_back(e);
                end
                cnt = (cnt + 1) % (N*N);
            end
        end
    end
    task automatic send_pixel(input int v);
        int  n;
        bit  acc;
        in_valid = 1'b1;
        in_data  = v;
        n = 0;
        do begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            n++;
        end while (!acc && n < 200);
        if (!acc) chk("accept_timeout", 0, 1);
        in_valid = 1'b0;
    endtask
    task automatic send_frame(input int base, input bit neg, input int pause_after);
        for (int i = 0; i < N*N; i++) begin
            send_pixel(neg ? -(base + i) : base + i);
            if (i == pause_after) begin
                int c0;
                c0 = acc_cnt;
                in_valid = 1'b1;
                in_data  = base + i + 1;
                enable   = 1'b0;
                repeat (4) begin
                    @(posedge clk);
                    #1;
                end
                chk("enable_hold_accepts", acc_cnt, c0);
                in_valid = 1'b0;
                enable   = 1'b1;
            end
        end
    endtask
    task automatic drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || out_valid) && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("drain_timeout", n < 100, 1);
        repeat (2) begin
            @(posedge clk);
            #1;
        end
    endtask
    task automatic check_seq(input string nm, input int e[9], input int off);
        for (int i = 0; i < 9; i++)
            if (off + i < log_q.size()) chk(nm, log_q[off+i], e[i]);
            else chk({nm, "_missing"}, 0, 1);
    endtask
    task automatic start_scenario();
        log_q.delete();
        fd_cnt = 0;
    endtask
    int seq_pos[9] = '{7, 9, 11, 19, 21, 23, 31, 33, 35};
    int seq_neg[9] = '{-100, -102, -104, -112, -114, -116, -124, -126, -128};
    int seq_hi[9]  = '{107, 109, 111, 119, 121, 123, 131, 133, 135};
    initial begin
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        // Ramp frame, continuous streaming.
        start_scenario();
        send_frame(0, 0, -1);
        drain();
        chk("s1_count", log_q.size(), 9);
        check_seq("s1_seq", seq_pos, 0);
        chk("s1_frame_done", fd_cnt, 1);
        // All-negative frame.
        start_scenario();
        send_frame(100, 1, -1);
        drain();
        chk("s2_count", log_q.size(), 9);
        check_seq("s2_seq", seq_neg, 0);
        // Output stall on the first result.
        start_scenario();
        fork
            begin
                int n;
                n = 0;
                do begin
                    @(posedge clk);
                    #1;
                    n++;
                end while (!out_valid && n < 500);
                chk("s3_first_seen", out_valid, 1);
                out_ready = 1'b0;
                repeat (5) begin
                    @(posedge clk);
                    #1;
                    chk("s3_stall_data", $signed(out_data), 7);
                    chk("s3_stall_in_ready", in_ready, 0);
                end
                out_ready = 1'b1;
            end
        join_none
        send_frame(0, 0, -1);
        drain();
        chk("s3_count", log_q.size(), 9);
        check_seq("s3_seq", seq_pos, 0);
        // Enable pause after pixel 14.
        start_scenario();
        send_frame(0, 0, 14);
        drain();
        chk("s4_count", log_q.size(), 9);
        check_seq("s4_seq", seq_pos, 0);
        // Reset mid-frame after pixel 20.
        for (int i = 0; i <= 20; i++) send_pixel(i);
        rst = 1'b1;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b0;
        start_scenario();
        send_frame(0, 0, -1);
        drain();
        chk("s5_count", log_q.size(), 9);
        check_seq("s5_seq", seq_pos, 0);
        // Back-to-back frames.
        start_scenario();
        send_frame(0, 0, -1);
        send_frame(100, 0, -1);
        drain();
        chk("s6_count", log_q.size(), 18);
        check_seq("s6_seq_a", seq_pos, 0);
        check_seq("s6_seq_b", seq_hi, 9);
        chk("s6_frame_done", fd_cnt, 2);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
